nbody_pair_sched: RTL
=====================

# nbody_pair_sched

Parametrised pair scheduler for the n-body accelerator. It sits between the memory-mapped control registers (GO, N_BODIES, GAP) and the fixed-latency force pipeline. Each simulation step it issues every ordered body pair (i, j) with i ≠ j under a valid/ready handshake. It tracks in-flight pairs through the pipeline latency, hands off to the integrator after the pipeline drains, and counts steps, raising snapshot and done events. It adds backpressure, a programmable step count, abort and configurable latency.

## Interface
- BODY_ADDR_WIDTH, 9, body index width; max bodies 2^BODY_ADDR_WIDTH
- LATENCY, 122, force pipeline latency in cycles (≥1)
- STEP_WIDTH, 16, width of step counters
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- go  in  1  start pulse; sampled only in IDLE or DONE
- abort  in  1  cancel run
- n_bodies  in  BODY_ADDR_WIDTH+1  body count, latched on accepted go
- gap  in  STEP_WIDTH  steps between snapshots (0 = none), latched on go
- num_steps  in  STEP_WIDTH  steps to run (0 = until abort), latched on go
- pipe_ready  in  1  force pipeline accepts a pair this cycle
- pair_valid  out  1  pair presented
- pair_i, pair_j  out  BODY_ADDR_WIDTH  pair indices
- pair_first, pair_last  out  1  first / last j for current i
- res_valid  out  1  pair_valid&pipe_ready delayed LATENCY cycles
- res_i  out  BODY_ADDR_WIDTH  delayed pair_i
- res_last  out  1  delayed pair_last (accumulator for res_i complete)
- update_start  out  1  one-cycle pulse: integrator may update all bodies
- update_done  in  1  integrator finished
- snapshot  out  1  one-cycle pulse: positions valid for host READ
- step_count  out  STEP_WIDTH  completed steps this run
- busy  out  1  state ≠ IDLE and ≠ DONE
- done  out  1  run complete (DONE state)

## Operation
- States: IDLE, ISSUE, DRAIN, UPDATE, DONE.
- IDLE/DONE + go: latch inputs, clear step_count. If n_bodies < 2, go to DONE. Otherwise go to ISSUE with i=0, j=1.
- n_bodies > 2^BODY_ADDR_WIDTH is clamped to 2^BODY_ADDR_WIDTH.
- ISSUE: order is i ascending, and within each i, j ascending with j=i skipped. There are N(N-1) pairs per step.
- pair_first marks the first j of an i; pair_last marks the last j.
- Indices advance only on pair_valid & pipe_ready.
- pair_valid and all pair fields stay stable while pipe_ready=0.
- The accept of (N-1, N-2) moves ISSUE to DRAIN.
- Delay line: a LATENCY-deep shift register carrying {valid, i, last}. It never stalls.
- DRAIN: leave when the delay line holds no valid entry. Then enter UPDATE with update_start pulsed for the first cycle only.
- UPDATE: wait for update_done. When it arrives:
  - step_count += 1 (wraps modulo 2^STEP_WIDTH).
  - Gap counter decrements; on reaching 0, snapshot pulses and the counter reloads gap (gap=0: never pulse).
  - If num_steps≠0 and step_count reaches num_steps, go to DONE; else go to ISSUE at (0,1).
- DONE: done=1. step_count holds until the next go.
- abort (any state, priority over all): go to IDLE next cycle and clear the delay line. No update_start or snapshot follows. step_count holds.
- go while busy is ignored. go and abort in the same cycle: abort wins.

## Timing
- Reset values: every output 0. The state resets to IDLE and the delay line clears.
- go accepted at cycle t → pair_valid=1 at t+1.
- Throughput is one pair per cycle with pipe_ready=1.
- Accept at cycle c → res_valid at c+LATENCY.
- Last res_valid at cycle r → update_start at r+1.
- update_done at cycle u → snapshot/step_count update at u+1, and also pair_valid or done at u+1.
- update_done asserted outside UPDATE is ignored.
- Reset mid-run: immediate return to reset values and no residual res_valid.

## Test plan
- LATENCY=4, N=3, num_steps=1, pipe_ready=1, go at t:
  - pairs (0,1)(0,2)(1,0)(1,2)(2,0)(2,1) at t+1..t+6, with pair_last on (0,2),(1,2),(2,1).
  - res_valid t+5..t+10, update_start t+11.
  - update_done at t+13 → done=1 and step_count=1 at t+14.
- Backpressure: N=21 with pipe_ready pseudo-random → 420 distinct pairs in order, no duplicates. Exactly 420 res_valid, 21 res_last.
- gap=2, num_steps=5, N=4: snapshot pulses after steps 2 and 4 only; done with step_count=5.
- abort during ISSUE at pair (1,0) → next cycle busy=0, pair_valid=0, no res_valid thereafter. A fresh go restarts at (0,1) with step_count=0.
- n_bodies=1 → done=1 at t+1, no pair_valid. n_bodies=0 gives the same. go during ISSUE is ignored.
- Async rst asserted mid-DRAIN → all outputs 0 without a clock edge. After release, go runs normally.

Source files
------------

// File: rtl/nbody_pair_sched.sv
// Pair scheduler for the n-body force pipeline: issues every ordered pair (i, j), i != j,
// tracks in-flight pairs through a fixed-latency delay line, then hands off to the integrator.
module nbody_pair_sched #(
  parameter int BODY_ADDR_WIDTH = 9,
  parameter int LATENCY         = 122,
  parameter int STEP_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic                       abort,
  input  logic [BODY_ADDR_WIDTH:0]   n_bodies,
  input  logic [STEP_WIDTH-1:0]      gap,
  input  logic [STEP_WIDTH-1:0]      num_steps,
  input  logic                       pipe_ready,
  output logic                       pair_valid,
  output logic [BODY_ADDR_WIDTH-1:0] pair_i,
  output logic [BODY_ADDR_WIDTH-1:0] pair_j,
  output logic                       pair_first,
  output logic                       pair_last,
  output logic                       res_valid,
  output logic [BODY_ADDR_WIDTH-1:0] res_i,
  output logic                       res_last,
  output logic                       update_start,
  input  logic                       update_done,
  output logic                       snapshot,
  output logic [STEP_WIDTH-1:0]      step_count,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 fsm_state
);
  localparam int AW = BODY_ADDR_WIDTH;
  localparam int NW = BODY_ADDR_WIDTH + 1;
  localparam logic [NW-1:0] MAX_N = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, UPDATE, DONE} state_t;
  state_t state;

  logic [NW-1:0]         n_lat;
  logic [STEP_WIDTH-1:0] gap_lat, num_lat, gap_cnt;
  logic [NW-1:0]         n_clamp, n_m1, i_ext, j_ext, nxt_i, nxt_j;
  logic                  nxt_first, nxt_last, issue_end, accept;
  logic [STEP_WIDTH-1:0] step_next;

  logic [LATENCY-1:0] dl_v, dl_l, drain_pend;
  logic [AW-1:0]      dl_i [LATENCY];

  // Handshake: a pair transfers in any cycle where pair_valid && pipe_ready; while
  // pipe_ready is low the presented pair holds every field unchanged.
  assign accept    = pair_valid & pipe_ready;
  assign n_clamp   = (n_bodies > MAX_N) ? MAX_N : n_bodies;
  assign n_m1      = n_lat - NW'(1);
  assign i_ext     = {1'b0, pair_i};
  assign j_ext     = {1'b0, pair_j};
  assign step_next = step_count + STEP_WIDTH'(1);

  assign busy      = (state == ISSUE) || (state == DRAIN) || (state == UPDATE);
  assign done      = (state == DONE);
  assign fsm_state = state;

  assign res_valid = dl_v[LATENCY-1];
  assign res_last  = dl_l[LATENCY-1];
  assign res_i     = dl_i[LATENCY-1];

  function automatic logic [NW-1:0] last_j(input logic [NW-1:0] i, input logic [NW-1:0] nm1);
    return (i == nm1) ? nm1 - NW'(1) : nm1;
  endfunction

  always_comb begin
    nxt_i     = i_ext;
    nxt_j     = j_ext;
    nxt_first = 1'b0;
    nxt_last  = 1'b0;
    issue_end = 1'b0;
    if (pair_last) begin
      if (i_ext == n_m1) begin
        issue_end = 1'b1;
      end else begin
        nxt_i     = i_ext + NW'(1);
        nxt_j     = '0;
        nxt_first = 1'b1;
        nxt_last  = (last_j(i_ext + NW'(1), n_m1) == '0);
      end
    end else begin
      nxt_j = j_ext + NW'(1);
      if (nxt_j == i_ext) nxt_j = j_ext + NW'(2);
      nxt_last = (nxt_j == last_j(i_ext, n_m1));
    end
  end

  // The top stage is about to leave the line, so it does not hold DRAIN back.
  always_comb begin
    drain_pend = dl_v;
    drain_pend[LATENCY-1] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_v <= '0;
      dl_l <= '0;
      for (int k = 0; k < LATENCY; k++) dl_i[k] <= '0;
    end else if (abort) begin
      dl_v <= '0;
      dl_l <= '0;
      for (int k = 0; k < LATENCY; k++) dl_i[k] <= '0;
    end else begin
      for (int k = LATENCY - 1; k > 0; k--) begin
        dl_v[k] <= dl_v[k-1];
        dl_l[k] <= dl_l[k-1];
        dl_i[k] <= dl_i[k-1];
      end
      dl_v[0] <= accept;
      dl_l[0] <= pair_last;
      dl_i[0] <= pair_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pair_valid   <= 1'b0;
      pair_i       <= '0;
      pair_j       <= '0;
      pair_first   <= 1'b0;
      pair_last    <= 1'b0;
      update_start <= 1'b0;
      snapshot     <= 1'b0;
      step_count   <= '0;
      n_lat        <= '0;
      gap_lat      <= '0;
      num_lat      <= '0;
      gap_cnt      <= '0;
    end else begin
      update_start <= 1'b0;
      snapshot     <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        pair_valid <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (go) begin
            n_lat      <= n_clamp;
            gap_lat    <= gap;
            num_lat    <= num_steps;
            gap_cnt    <= gap;
            step_count <= '0;
            if (n_bodies < NW'(2)) begin
              state <= DONE;
            end else begin
              state      <= ISSUE;
              pair_valid <= 1'b1;
              pair_i     <= '0;
              pair_j     <= AW'(1);
              pair_first <= 1'b1;
              pair_last  <= (n_bodies == NW'(2));
            end
          end
          ISSUE: if (accept) begin
            if (issue_end) begin
              state      <= DRAIN;
              pair_valid <= 1'b0;
            end else begin
              pair_i     <= nxt_i[AW-1:0];
              pair_j     <= nxt_j[AW-1:0];
              pair_first <= nxt_first;
              pair_last  <= nxt_last;
            end
          end
          DRAIN: if (drain_pend == '0) begin
            state        <= UPDATE;
            update_start <= 1'b1;
          end
          UPDATE: if (update_done) begin
            step_count <= step_next;
            if (gap_lat != '0) begin
              if (gap_cnt == STEP_WIDTH'(1)) begin
                snapshot <= 1'b1;
                gap_cnt  <= gap_lat;
              end else begin
                gap_cnt <= gap_cnt - STEP_WIDTH'(1);
              end
            end
            if ((num_lat != '0) && (step_next == num_lat)) begin
              state <= DONE;
            end else begin
              state      <= ISSUE;
              pair_valid <= 1'b1;
              pair_i     <= '0;
              pair_j     <= AW'(1);
              pair_first <= 1'b1;
              pair_last  <= (n_lat == NW'(2));
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
